rcp_word_sequencer: RTL and testbench

- Tracks word position within each packet on the 64-bit NetFPGA datapath and generates the per-word select strobes that drive the RCP header parser: word_RCP_FIRST, word_RCP_THIRD, word_RCP_RTT and word_RCP_FRATE.
- Sits beside the parser in the rcp_router user datapath and snoops the same in_data/in_ctrl/in_wr bus. It does not stall the bus.
- Gates the RTT/FRATE strobes on protocol match and keeps packet statistics.

---
 rtl/rcp_word_sequencer.sv | 154 +++++++++++++++
 tb/tb_rcp_word_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcp_word_sequencer.sv
// rcp_word_sequencer: snoops the 64-bit NetFPGA datapath, tracks the word
// position inside each packet and raises the zero-latency select strobes that
// steer the RCP header parser. It also tracks protocol match and keeps packet
// statistics. It never stalls the bus.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   in_data/ctrl/wr snooped datapath word (transfers when in_wr=1)
//   rcp_enable      0 suppresses THIRD/RTT/FRATE strobes (FIRST unaffected)
//   word_RCP_*      combinational per-word select strobes
//   rcp_match       registered: current packet carries the RCP protocol
//   pkt_cnt         registered: packets completed
//   rcp_pkt_cnt     registered: completed packets that were RCP
//   trunc_cnt       registered: RCP packets that ended before the FRATE word
module rcp_word_sequencer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter logic [7:0]  IOQ_CTRL   = 8'hFF,
  parameter logic [7:0]  RCP_TYPE   = 8'hFE,
  parameter int unsigned THIRD_WORD = 2,
  parameter int unsigned RTT_WORD   = 5,
  parameter int unsigned FRATE_WORD = 6,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  input  logic                  rcp_enable,
  output logic                  word_RCP_FIRST,
  output logic                  word_RCP_THIRD,
  output logic                  word_RCP_RTT,
  output logic                  word_RCP_FRATE,
  output logic                  rcp_match,
  output logic [31:0]           pkt_cnt,
  output logic [31:0]           rcp_pkt_cnt,
  output logic [15:0]           trunc_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic {HDR, PAYLOAD} state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] word_cnt;
  logic                 first_seen;

  logic                 ctrl_zero;
  logic                 ioq_word;
  logic                 hdr_word;
  logic                 pay_word;
  logic                 eop_word;
  logic [CNT_WIDTH-1:0] idx;
  logic                 at_third;
  logic                 at_rtt;
  logic                 at_frate;
  logic                 before_frate;
  logic                 match_after;

  // Only the protocol byte of the snooped data is inspected.
  logic                 unused_data;
  assign unused_data = ^in_data[DATA_WIDTH-1:8];

  // Word classification and payload index decode.
  assign ctrl_zero    = (in_ctrl == '0);
  assign ioq_word     = (in_ctrl == CTRL_WIDTH'(IOQ_CTRL));
  assign hdr_word     = in_wr && (state == HDR) && !ctrl_zero;
  assign pay_word     = in_wr && ((state == PAYLOAD) || ctrl_zero);
  assign eop_word     = in_wr && (state == PAYLOAD) && !ctrl_zero;
  assign idx          = (state == HDR) ? '0 : word_cnt;
  assign at_third     = (32'(idx) == THIRD_WORD);
  assign at_rtt       = (32'(idx) == RTT_WORD);
  assign at_frate     = (32'(idx) == FRATE_WORD);
  assign before_frate = (32'(idx) < FRATE_WORD);

  // Match status including an update landing on this very word (third-word EOP).
  assign match_after = at_third ? (rcp_enable && (in_data[7:0] == RCP_TYPE))
                                : rcp_match;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HDR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      HDR:     if (in_wr && ctrl_zero)  state_next = PAYLOAD;
      PAYLOAD: if (eop_word)            state_next = HDR;
      default:                          state_next = HDR;
    endcase
  end

  // Zero-latency strobes; RTT/FRATE rely on rcp_match, which is only ever set
  // by the third word, so indices at or before it can never fire them.
  always_comb begin
    word_RCP_FIRST = 1'b0;
    word_RCP_THIRD = 1'b0;
    word_RCP_RTT   = 1'b0;
    word_RCP_FRATE = 1'b0;
    if (!reset) begin
      word_RCP_FIRST = hdr_word && ioq_word && !first_seen;
      word_RCP_THIRD = pay_word && rcp_enable && at_third;
      word_RCP_RTT   = pay_word && rcp_enable && rcp_match && at_rtt;
      word_RCP_FRATE = pay_word && rcp_enable && rcp_match && at_frate;
    end
  end

  // Word counter, header tracking, match flag and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt    <= '0;
      first_seen  <= 1'b0;
      rcp_match   <= 1'b0;
      pkt_cnt     <= '0;
      rcp_pkt_cnt <= '0;
      trunc_cnt   <= '0;
    end else begin
      if (hdr_word && ioq_word) begin
        first_seen <= 1'b1;
      end
      if (eop_word) begin
        word_cnt   <= '0;
        first_seen <= 1'b0;
        rcp_match  <= 1'b0;
        pkt_cnt    <= pkt_cnt + 32'd1;
        if (match_after) begin
          rcp_pkt_cnt <= rcp_pkt_cnt + 32'd1;
        end
        if (match_after && before_frate) begin
          trunc_cnt <= trunc_cnt + 16'd1;
        end
      end else if (pay_word) begin
        // Saturate so late words of long packets never alias early indices.
        if (state == HDR) begin
          word_cnt <= CNT_WIDTH'(1);
        end else if (word_cnt != CNT_MAX) begin
          word_cnt <= word_cnt + CNT_WIDTH'(1);
        end
        if (at_third) begin
          rcp_match <= match_after;
        end
      end
    end
  end

endmodule

// File: tb/tb_rcp_word_sequencer.sv
// Testbench for rcp_word_sequencer: table-driven first packet, hand-written
// corner sequences and randomized packets checked against a packet-level model.
module tb_rcp_word_sequencer;

  logic        clk;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        rcp_enable;
  logic        word_RCP_FIRST;
  logic        word_RCP_THIRD;
  logic        word_RCP_RTT;
  logic        word_RCP_FRATE;
  logic        rcp_match;
  logic [31:0] pkt_cnt;
  logic [31:0] rcp_pkt_cnt;
  logic [15:0] trunc_cnt;

  rcp_word_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_ctrl        (in_ctrl),
    .in_wr          (in_wr),
    .rcp_enable     (rcp_enable),
    .word_RCP_FIRST (word_RCP_FIRST),
    .word_RCP_THIRD (word_RCP_THIRD),
    .word_RCP_RTT   (word_RCP_RTT),
    .word_RCP_FRATE (word_RCP_FRATE),
    .rcp_match      (rcp_match),
    .pkt_cnt        (pkt_cnt),
    .rcp_pkt_cnt    (rcp_pkt_cnt),
    .trunc_cnt      (trunc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Strobe occurrence counts observed on the DUT.
  int obs_first = 0;
  int obs_third = 0;
  int obs_rtt   = 0;
  int obs_frate = 0;

  // Packet-level reference model state (index is an unbounded integer).
  bit          m_in_pkt;
  int          m_idx;
  bit          m_first;
  bit          m_match;
  int unsigned m_pkt;
  int unsigned m_rcp;
  int unsigned m_trunc;

  typedef struct {
    logic        wr;
    logic [7:0]  ctrl;
    logic [63:0] data;
    logic        en;
    logic        first;
    logic        third;
    logic        rtt;
    logic        frate;
    logic        match;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_in_pkt = 0; m_idx = 0; m_first = 0; m_match = 0;
    m_pkt = 0; m_rcp = 0; m_trunc = 0;
  endtask

  // Applies the word rules to the model; returns the strobes expected for it.
  task automatic model_word(input logic wr, input logic [7:0] ctrl, input logic [63:0] data,
                            input logic en, output logic ef, output logic et,
                            output logic er, output logic efr);
    int  i;
    bit  nm;
    ef = 0; et = 0; er = 0; efr = 0;
    if (wr) begin
      if (!m_in_pkt && ctrl != 8'h00) begin
        if (ctrl == 8'hFF) begin
          ef = !m_first;
          m_first = 1;
        end
      end else begin
        i   = m_in_pkt ? m_idx : 0;
        et  = en && (i == 2);
        er  = m_match && en && (i == 5);
        efr = m_match && en && (i == 6);
        nm  = (i == 2) ? (en && data[7:0] == 8'hFE) : m_match;
        if (m_in_pkt && ctrl != 8'h00) begin
          m_pkt++;
          if (nm) m_rcp++;
          if (nm && i < 6) m_trunc++;
          m_in_pkt = 0; m_idx = 0; m_first = 0; m_match = 0;
        end else begin
          m_in_pkt = 1; m_idx = i + 1; m_match = nm;
        end
      end
    end
  endtask

  task automatic count_obs();
    if (word_RCP_FIRST) obs_first++;
    if (word_RCP_THIRD) obs_third++;
    if (word_RCP_RTT)   obs_rtt++;
    if (word_RCP_FRATE) obs_frate++;
  endtask

  // Drive one cycle, check strobes before the edge and registers after it.
  task automatic apply_word(input logic wr, input logic [7:0] ctrl, input logic [63:0] data,
                            input logic en);
    logic ef, et, er, efr;
    @(negedge clk);
    in_wr = wr; in_ctrl = ctrl; in_data = data; rcp_enable = en;
    model_word(wr, ctrl, data, en, ef, et, er, efr);
    #1;
    chk("first", 32'(word_RCP_FIRST), 32'(ef));
    chk("third", 32'(word_RCP_THIRD), 32'(et));
    chk("rtt",   32'(word_RCP_RTT),   32'(er));
    chk("frate", 32'(word_RCP_FRATE), 32'(efr));
    count_obs();
    @(posedge clk);
    #1;
    chk("rcp_match",   32'(rcp_match),   32'(m_match));
    chk("pkt_cnt",     pkt_cnt,          m_pkt);
    chk("rcp_pkt_cnt", rcp_pkt_cnt,      m_rcp);
    chk("trunc_cnt",   32'(trunc_cnt),   32'(m_trunc[15:0]));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Header of n_ff IOQ words, n_pay payload words (last one EOP), optional idle gap.
  task automatic send_pkt(input int n_ff, input int n_pay, input logic [7:0] proto,
                          input int gap_at, input int gap_len);
    logic [63:0] d;
    for (int h = 0; h < n_ff; h++) apply_word(1'b1, 8'hFF, rnd64(), 1'b1);
    for (int i = 0; i < n_pay; i++) begin
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) apply_word(1'b0, 8'($urandom), rnd64(), 1'b1);
      d = rnd64();
      if (i == 2) d[7:0] = proto;
      apply_word(1'b1, (i == n_pay - 1) ? 8'h01 : 8'h00, d, 1'b1);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] ctrl, input logic [7:0] b0,
                              input logic f, input logic t, input logic r, input logic fr,
                              input logic m);
    vec_t v;
    v.wr = wr; v.ctrl = ctrl; v.data = {56'h0123_4567_89AB_CD, b0}; v.en = 1'b1;
    v.first = f; v.third = t; v.rtt = r; v.frate = fr; v.match = m;
    return v;
  endfunction

  int base_first, base_third, base_rtt, base_frate;

  task automatic snap();
    base_first = obs_first; base_third = obs_third;
    base_rtt = obs_rtt; base_frate = obs_frate;
  endtask

  initial begin
    logic ef, et, er, efr;
    logic [7:0]  c;
    logic [63:0] d;
    int nh, np;

    // wr ctrl byte0 | first third rtt frate | match after edge
    vecs[0] = mk(1, 8'hFF, 8'h00, 1, 0, 0, 0, 0);
    vecs[1] = mk(0, 8'hFF, 8'h00, 0, 0, 0, 0, 0);
    vecs[2] = mk(1, 8'h00, 8'h11, 0, 0, 0, 0, 0);
    vecs[3] = mk(1, 8'h00, 8'h22, 0, 0, 0, 0, 0);
    vecs[4] = mk(1, 8'h00, 8'hFE, 0, 1, 0, 0, 1);
    vecs[5] = mk(1, 8'h00, 8'h33, 0, 0, 0, 0, 1);
    vecs[6] = mk(1, 8'h00, 8'h44, 0, 0, 0, 0, 1);
    vecs[7] = mk(1, 8'h00, 8'h55, 0, 0, 1, 0, 1);
    vecs[8] = mk(1, 8'h00, 8'h66, 0, 0, 0, 1, 1);
    vecs[9] = mk(1, 8'h01, 8'h77, 0, 0, 0, 0, 0);

    reset = 1'b1; in_wr = 1'b0; in_ctrl = '0; in_data = '0; rcp_enable = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_match", 32'(rcp_match), 32'd0);
    chk("reset_pkt",   pkt_cnt,        32'd0);
    chk("reset_rcp",   rcp_pkt_cnt,    32'd0);
    chk("reset_trunc", 32'(trunc_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic matched packet from the vector table.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_wr = vecs[k].wr; in_ctrl = vecs[k].ctrl; in_data = vecs[k].data;
      rcp_enable = vecs[k].en;
      model_word(vecs[k].wr, vecs[k].ctrl, vecs[k].data, vecs[k].en, ef, et, er, efr);
      #1;
      chk($sformatf("vec%0d_first", k), 32'(word_RCP_FIRST), 32'(vecs[k].first));
      chk($sformatf("vec%0d_third", k), 32'(word_RCP_THIRD), 32'(vecs[k].third));
      chk($sformatf("vec%0d_rtt", k),   32'(word_RCP_RTT),   32'(vecs[k].rtt));
      chk($sformatf("vec%0d_frate", k), 32'(word_RCP_FRATE), 32'(vecs[k].frate));
      count_obs();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_match", k), 32'(rcp_match), 32'(vecs[k].match));
    end
    chk("t1_pkt",   pkt_cnt,        32'd1);
    chk("t1_rcp",   rcp_pkt_cnt,    32'd1);
    chk("t1_trunc", 32'(trunc_cnt), 32'd0);

    // Non-RCP protocol: THIRD fires, RTT/FRATE never do.
    snap();
    send_pkt(1, 8, 8'h06, -1, 0);
    chk("t2_third", 32'(obs_third - base_third), 32'd1);
    chk("t2_rtt",   32'(obs_rtt - base_rtt),     32'd0);
    chk("t2_frate", 32'(obs_frate - base_frate), 32'd0);
    chk("t2_pkt",   pkt_cnt,     32'd2);
    chk("t2_rcp",   rcp_pkt_cnt, 32'd1);

    // Matched packet ending on the RTT word: truncated.
    snap();
    send_pkt(1, 6, 8'hFE, -1, 0);
    chk("t3_rtt",   32'(obs_rtt - base_rtt),     32'd1);
    chk("t3_frate", 32'(obs_frate - base_frate), 32'd0);
    chk("t3_pkt",   pkt_cnt,        32'd3);
    chk("t3_rcp",   rcp_pkt_cnt,    32'd2);
    chk("t3_trunc", 32'(trunc_cnt), 32'd1);

    // Two IOQ header words and a 3-cycle idle gap inside the payload.
    snap();
    send_pkt(2, 8, 8'hFE, 3, 3);
    chk("t4_first", 32'(obs_first - base_first), 32'd1);
    chk("t4_rtt",   32'(obs_rtt - base_rtt),     32'd1);
    chk("t4_frate", 32'(obs_frate - base_frate), 32'd1);
    chk("t4_pkt",   pkt_cnt,     32'd4);

    // Long packet past counter saturation: FRATE exactly once.
    snap();
    send_pkt(1, 20, 8'hFE, -1, 0);
    chk("t5_frate", 32'(obs_frate - base_frate), 32'd1);
    chk("t5_rtt",   32'(obs_rtt - base_rtt),     32'd1);
    chk("t5_third", 32'(obs_third - base_third), 32'd1);
    chk("t5_pkt",   pkt_cnt,        32'd5);
    chk("t5_rcp",   rcp_pkt_cnt,    32'd4);
    chk("t5_trunc", 32'(trunc_cnt), 32'd1);

    // Randomized packets with idle gaps and rcp_enable toggling.
    repeat (40) begin
      nh = $urandom_range(0, 3);
      for (int h = 0; h < nh; h++) begin
        c = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(1, 254));
        apply_word(1'b1, c, rnd64(), ($urandom_range(0, 4) != 0));
      end
      np = $urandom_range(2, 20);
      for (int i = 0; i < np; i++) begin
        if ($urandom_range(0, 4) == 0)
          apply_word(1'b0, 8'($urandom), rnd64(), 1'($urandom));
        d = rnd64();
        if (i == 2 && $urandom_range(0, 2) != 0) d[7:0] = 8'hFE;
        c = (i == np - 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        apply_word(1'b1, c, d, ($urandom_range(0, 9) != 0));
      end
    end

    // Asynchronous reset landing on the RTT word of a matched packet.
    send_pkt(1, 0, 8'h00, -1, 0);
    for (int i = 0; i < 5; i++) begin
      d = rnd64();
      if (i == 2) d[7:0] = 8'hFE;
      apply_word(1'b1, 8'h00, d, 1'b1);
    end
    @(negedge clk);
    in_wr = 1'b1; in_ctrl = 8'h00; in_data = rnd64(); rcp_enable = 1'b1;
    #1;
    chk("pre_reset_rtt", 32'(word_RCP_RTT), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_rtt",   32'(word_RCP_RTT),   32'd0);
    chk("arst_first", 32'(word_RCP_FIRST), 32'd0);
    chk("arst_match", 32'(rcp_match),      32'd0);
    chk("arst_pkt",   pkt_cnt,             32'd0);
    chk("arst_rcp",   rcp_pkt_cnt,         32'd0);
    chk("arst_trunc", 32'(trunc_cnt),      32'd0);
    @(negedge clk);
    in_wr = 1'b0;
    reset = 1'b0;
    model_reset();
    snap();
    send_pkt(1, 8, 8'hFE, -1, 0);
    chk("t6_first", 32'(obs_first - base_first), 32'd1);
    chk("t6_frate", 32'(obs_frate - base_frate), 32'd1);
    chk("t6_pkt",   pkt_cnt,     32'd1);
    chk("t6_rcp",   rcp_pkt_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
